// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target at DEV_ADDR with a byte pointer and a 2**PTR_W byte register file.
// SCL/SDA are oversampled on clk; SCL is never stretched.
module i2c_slave_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h48,
   parameter int         PTR_W    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scl,
   inout  wire              sda,
   input  logic             ld,
   input  logic [PTR_W-1:0] ld_addr,
   input  logic [7:0]       ld_data,
   output logic             wr_strobe,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic             busy
);
   localparam int DEPTH = 2 ** PTR_W;
   typedef enum logic [3:0] {IDLE, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_W, RDATA, MACK, WAIT} state_t;
   state_t           st;
   logic [1:0]       scl_sy, sda_sy;
   logic             scl_d, sda_d, sda_oe, rw;
   logic [7:0]       file [DEPTH];
   logic [PTR_W-1:0] ptr, nxt;
   logic [7:0]       shift, byte_in;
   logic [3:0]       cnt;
   logic             scl_s, sda_s, rise, fall, start, stop, last;
   assign sda     = sda_oe ? 1'b0 : 1'bz;
   assign scl_s   = scl_sy[1];
   assign sda_s   = sda_sy[1];
   assign rise    = scl_s & ~scl_d;
   assign fall    = ~scl_s & scl_d;
   assign start   = scl_s & scl_d & sda_d & ~sda_s;
   assign stop    = scl_s & scl_d & ~sda_d & sda_s;
   assign byte_in = {shift[6:0], sda_s};
   assign last    = cnt == 4'd7;
   assign nxt     = ptr + PTR_W'(1);
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sy    <= 2'b11;
         sda_sy    <= 2'b11;
         scl_d     <= 1'b1;
         sda_d     <= 1'b1;
         st        <= IDLE;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         ptr       <= '0;
         shift     <= '0;
         cnt       <= '0;
         rw        <= 1'b0;
         for (int i = 0; i < DEPTH; i++) file[i] <= '0;
      end else begin
         scl_sy    <= {scl_sy[0], scl};
         sda_sy    <= {sda_sy[0], sda};
         scl_d     <= scl_s;
         sda_d     <= sda_s;
         wr_strobe <= 1'b0;
         // the I2C write further down lands after this, so it wins on an index collision
         if (ld) file[ld_addr] <= ld_data;
         if (start) begin
            st     <= ADDR;
            cnt    <= '0;
            sda_oe <= 1'b0;
         end else if (stop) begin
            st     <= IDLE;
            busy   <= 1'b0;
            sda_oe <= 1'b0;
         end else begin
            case (st)
               ADDR: if (rise) begin
                  shift <= byte_in;
                  cnt   <= cnt + 4'd1;
                  if (last) begin
                     cnt  <= '0;
                     rw   <= byte_in[0];
                     busy <= byte_in[7:1] == DEV_ADDR;
                     st   <= byte_in[7:1] == DEV_ADDR ? ACK_A : IDLE;
                  end
               end
               PTR, WDATA: if (rise) begin
                  shift <= byte_in;
                  cnt   <= cnt + 4'd1;
                  if (last) begin
                     cnt <= '0;
                     if (st == PTR) begin
                        ptr <= byte_in[PTR_W-1:0];
                        st  <= ACK_P;
                     end else begin
                        file[ptr] <= byte_in;
                        wr_strobe <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= byte_in;
                        ptr       <= nxt;
                        st        <= ACK_W;
                     end
                  end
               end
               // first fall starts the ACK pulse, second fall ends it and moves on
               ACK_A, ACK_P, ACK_W: if (fall) begin
                  if (cnt == 4'd0) begin
                     sda_oe <= 1'b1;
                     cnt    <= 4'd1;
                  end else begin
                     cnt    <= '0;
                     shift  <= file[ptr];
                     sda_oe <= st == ACK_A && rw && !file[ptr][7];
                     st     <= st != ACK_A ? WDATA : rw ? RDATA : PTR;
                  end
               end
               RDATA: begin
                  if (rise) cnt <= cnt + 4'd1;
                  if (fall) begin
                     shift  <= {shift[6:0], 1'b0};
                     sda_oe <= cnt != 4'd8 && !shift[6];
                     if (cnt == 4'd8) begin
                        cnt <= '0;
                        st  <= MACK;
                     end
                  end
               end
               MACK: begin
                  if (rise) begin
                     if (sda_s) st <= WAIT;
                     else cnt <= 4'd1;
                  end
                  if (fall && cnt == 4'd1) begin
                     ptr    <= nxt;
                     shift  <= file[nxt];
                     sda_oe <= !file[nxt][7];
                     cnt    <= '0;
                     st     <= RDATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master driving the register-file slave,
// checked against a byte-array model of the file and pointer.
module tb_i2c_slave_regfile;
   localparam int Q = 6;
   logic       clk = 1'b0, reset = 1'b1, scl = 1'b1, m_low = 1'b0, ld = 1'b0;
   logic [1:0] ld_addr = '0;
   logic [7:0] ld_data = '0;
   wire        sda;
   logic       wr_strobe, busy;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   int         checks = 0, errors = 0;
   logic [7:0] mfile [4];
   logic [1:0] mptr;
   logic [9:0] wq [$];

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;
   always #5 clk = ~clk;

   i2c_slave_regfile #(.DEV_ADDR(7'h48), .PTR_W(2)) dut (
      .clk(clk), .reset(reset), .scl(scl), .sda(sda), .ld(ld), .ld_addr(ld_addr), .ld_data(ld_data),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   always @(negedge clk) if (wr_strobe) wq.push_back({wr_addr, wr_data});

   typedef struct {
      logic [7:0]  dev;
      logic [7:0]  p;
      logic [31:0] d;
      int          n;
      logic        exp_ack;
      int          exp_str;
      logic [1:0]  exp_last;
   } vec_t;
   vec_t tbl [6];

   function automatic logic rd();
      return (sda === 1'b0) ? 1'b0 : 1'b1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_ld(input logic [1:0] a, input logic [7:0] v);
      ld = 1'b1; ld_addr = a; ld_data = v;
      tick(1);
      ld = 1'b0;
      mfile[a] = v;
   endtask

   // optional ld pulse lands on the exact clk the slave commits the 8th data bit
   task automatic bit_cycle(input logic b, input logic col, input logic [1:0] ca, input logic [7:0] cd, output logic s);
      m_low = ~b;
      tick(Q);
      scl = 1'b1;
      if (col) begin
         tick(2);
         ld = 1'b1; ld_addr = ca; ld_data = cd;
         tick(1);
         ld = 1'b0;
         tick(Q - 3);
      end else tick(Q);
      s = rd();
      tick(Q);
      scl = 1'b0;
      tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] v, input logic col, input logic [1:0] ca, input logic [7:0] cd, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(v[i], col && i == 0, ca, cd, s);
      bit_cycle(1'b1, 1'b0, 2'd0, 8'd0, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] v, output logic ninth);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, 1'b0, 2'd0, 8'd0, s);
         v[i] = s;
      end
      bit_cycle(~ack, 1'b0, 2'd0, 8'd0, ninth);
   endtask

   task automatic i2c_start();
      m_low = 1'b1; tick(Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_restart();
      m_low = 1'b0; tick(Q);
      scl = 1'b1; tick(Q);
      m_low = 1'b1; tick(Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; tick(Q);
      scl = 1'b1; tick(Q);
      m_low = 1'b0; tick(Q);
   endtask

   task automatic xfer_write(input logic [7:0] dev, input logic [7:0] p, input logic [31:0] d, input int n,
                             input logic col, input logic [1:0] ca, input logic [7:0] cd, input string nm,
                             output logic aa);
      logic a, m, lst;
      logic [7:0] v;
      logic [9:0] eq [$];
      m = dev == 8'h90;
      wq.delete();
      i2c_start();
      write_byte(dev, 1'b0, 2'd0, 8'd0, aa);
      chk({nm, " addr ack"}, aa, m);
      chk({nm, " busy"}, busy, m);
      write_byte(p, 1'b0, 2'd0, 8'd0, a);
      chk({nm, " ptr ack"}, a, m);
      if (m) mptr = p[1:0];
      for (int i = 0; i < n; i++) begin
         v = d[8*i +: 8];
         lst = col && i == n - 1;
         write_byte(v, lst, ca, cd, a);
         chk({nm, " data ack"}, a, m);
         if (lst) mfile[ca] = cd;
         if (m) begin
            mfile[mptr] = v;
            eq.push_back({mptr, v});
            mptr++;
         end
      end
      i2c_stop();
      tick(4);
      chk({nm, " busy after stop"}, busy, 0);
      chk({nm, " strobe count"}, wq.size(), eq.size());
      foreach (eq[i]) if (i < wq.size()) chk({nm, " strobe addr/data"}, wq[i], eq[i]);
   endtask

   task automatic xfer_read(input logic [7:0] p, input int n, input logic setp, input string nm);
      logic a, nine;
      logic [7:0] v;
      i2c_start();
      if (setp) begin
         write_byte(8'h90, 1'b0, 2'd0, 8'd0, a);
         chk({nm, " waddr ack"}, a, 1);
         write_byte(p, 1'b0, 2'd0, 8'd0, a);
         chk({nm, " ptr ack"}, a, 1);
         mptr = p[1:0];
         i2c_restart();
      end
      write_byte(8'h91, 1'b0, 2'd0, 8'd0, a);
      chk({nm, " raddr ack"}, a, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(i != n - 1, v, nine);
         chk({nm, " data"}, v, mfile[mptr]);
         if (i != n - 1) mptr++;
         else chk({nm, " sda released after nack"}, nine, 1);
      end
      i2c_stop();
      tick(4);
      chk({nm, " busy after stop"}, busy, 0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic aa, s;
      logic [7:0] p;
      foreach (mfile[i]) mfile[i] = 8'h00;
      mptr = 2'd0;
      tbl[0] = '{dev: 8'h90, p: 8'h01, d: 32'h000000A5, n: 1, exp_ack: 1'b1, exp_str: 1, exp_last: 2'd1};
      tbl[1] = '{dev: 8'h90, p: 8'h03, d: 32'h00002211, n: 2, exp_ack: 1'b1, exp_str: 2, exp_last: 2'd0};
      tbl[2] = '{dev: 8'h92, p: 8'h01, d: 32'h000000A5, n: 1, exp_ack: 1'b0, exp_str: 0, exp_last: 2'd0};
      tbl[3] = '{dev: 8'h90, p: 8'hFE, d: 32'h0000005A, n: 1, exp_ack: 1'b1, exp_str: 1, exp_last: 2'd2};
      tbl[4] = '{dev: 8'h90, p: 8'h00, d: 32'h04030201, n: 4, exp_ack: 1'b1, exp_str: 4, exp_last: 2'd3};
      tbl[5] = '{dev: 8'h90, p: 8'h02, d: 32'h00000FF0, n: 2, exp_ack: 1'b1, exp_str: 2, exp_last: 2'd3};
      tick(4);
      reset = 1'b0;
      tick(2);
      chk("reset busy", busy, 0);
      chk("reset wr_strobe", wr_strobe, 0);
      chk("reset wr_addr", wr_addr, 0);
      chk("reset wr_data", wr_data, 0);
      chk("reset sda released", rd(), 1);

      for (int k = 0; k < 6; k++) begin
         xfer_write(tbl[k].dev, tbl[k].p, tbl[k].d, tbl[k].n, 1'b0, 2'd0, 8'd0, $sformatf("tbl%0d", k), aa);
         chk("tbl addr ack", aa, tbl[k].exp_ack);
         chk("tbl strobes", wq.size(), tbl[k].exp_str);
         if (tbl[k].exp_str > 0) chk("tbl last wr_addr", wq[wq.size()-1][9:8], tbl[k].exp_last);
         if (k == 1) xfer_read(8'h03, 2, 1'b1, "wrap readback");
      end
      xfer_read(8'h00, 4, 1'b1, "tbl readback");

      do_ld(2'd2, 8'h3C);
      do_ld(2'd3, 8'h7E);
      xfer_read(8'h02, 2, 1'b1, "read ack/nack");
      xfer_read(8'h00, 1, 1'b0, "read kept ptr");

      wq.delete();
      i2c_start();
      write_byte(8'h90, 1'b0, 2'd0, 8'd0, aa);
      write_byte(8'h01, 1'b0, 2'd0, 8'd0, aa);
      mptr = 2'd1;
      for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b0, 2'd0, 8'd0, s);
      i2c_stop();
      tick(4);
      chk("abort busy", busy, 0);
      chk("abort no strobe", wq.size(), 0);
      xfer_read(8'h01, 1, 1'b1, "abort file kept");
      xfer_write(8'h90, 8'h01, 32'h000000B7, 1, 1'b0, 2'd0, 8'd0, "after abort", aa);

      xfer_write(8'h90, 8'h01, 32'h000000C3, 1, 1'b1, 2'd1, 8'h5A, "collide same", aa);
      xfer_read(8'h01, 1, 1'b1, "collide same rb");
      xfer_write(8'h90, 8'h01, 32'h00000066, 1, 1'b1, 2'd2, 8'h99, "collide diff", aa);
      xfer_read(8'h01, 2, 1'b1, "collide diff rb");

      do_ld(2'd0, 8'h00);
      i2c_start();
      write_byte(8'h90, 1'b0, 2'd0, 8'd0, aa);
      write_byte(8'h00, 1'b0, 2'd0, 8'd0, aa);
      i2c_restart();
      write_byte(8'h91, 1'b0, 2'd0, 8'd0, aa);
      for (int i = 0; i < 3; i++) bit_cycle(1'b1, 1'b0, 2'd0, 8'd0, s);
      chk("rdata driving low", rd(), 0);
      chk("rdata busy", busy, 1);
      reset = 1'b1;
      tick(1);
      chk("mid reset sda released", rd(), 1);
      chk("mid reset busy", busy, 0);
      chk("mid reset wr_strobe", wr_strobe, 0);
      chk("mid reset wr_addr", wr_addr, 0);
      chk("mid reset wr_data", wr_data, 0);
      reset = 1'b0;
      foreach (mfile[i]) mfile[i] = 8'h00;
      mptr = 2'd0;
      i2c_stop();
      tick(4);
      xfer_read(8'h00, 4, 1'b1, "post reset file");

      for (int it = 0; it < 16; it++) begin
         case ($urandom_range(0, 3))
            0: do_ld(2'($urandom_range(0, 3)), 8'($urandom));
            1: xfer_write(($urandom_range(0, 3) == 0) ? 8'h92 : 8'h90, 8'($urandom), $urandom,
                          $urandom_range(0, 3), 1'b0, 2'd0, 8'd0, "rand write", aa);
            2: begin
               p = 8'($urandom);
               xfer_read(p, $urandom_range(1, 4), 1'b1, "rand read");
            end
            default: xfer_read(8'h00, $urandom_range(1, 3), 1'b0, "rand read cur");
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
